// File: rtl/tlc_phase_fsm_if.sv
// Timer handshake shared between the phase sequencer (master) and the n-bit timer (slave).
// The sequencer enables the timer and sets its limit; the timer reports when it reaches that limit.
interface tlc_phase_fsm_if #(
    parameter int n = 6
);
    logic         timer_en;
    logic [n-1:0] t_max;
    logic         timer_done;

    modport master (
        output timer_en,
        output t_max,
        input  timer_done
    );

    modport slave (
        input  timer_en,
        input  t_max,
        output timer_done
    );
endinterface

// File: rtl/tlc_phase_fsm.sv
// Traffic light phase sequencer: steps main/side roads through their phases on timer_done,
// with side-road car sensing and a latched pedestrian request served after the side phase.
module tlc_phase_fsm #(
    parameter int n        = 6,
    parameter int T_MG_MIN = 9,
    parameter int T_Y      = 2,
    parameter int T_AR     = 1,
    parameter int T_SG     = 7,
    parameter int T_PED    = 5
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 side_car,
    input  logic                 ped_req,
    tlc_phase_fsm_if.master      tif,
    output logic [2:0]           main_light,
    output logic [2:0]           side_light,
    output logic                 ped_walk,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5,
        PED = 3'd6
    } phase_e;

    localparam logic [n-1:0] LIM_MG  = n'(T_MG_MIN);
    localparam logic [n-1:0] LIM_Y   = n'(T_Y);
    localparam logic [n-1:0] LIM_AR  = n'(T_AR);
    localparam logic [n-1:0] LIM_SG  = n'(T_SG);
    localparam logic [n-1:0] LIM_PED = n'(T_PED);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Kept as a plain vector so the unused code 7 can exist and be recovered from.
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       ped_pending;
    logic       mg_request;

    assign mg_request = side_car | ped_pending;
    assign state      = state_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= MG;
        end else begin
            state_q <= state_d;
        end
    end

    // Clearing on entry to PED beats a same-cycle press, so one walk serves all waiting requests.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ped_pending <= 1'b0;
        end else if ((state_q == AR2) && tif.timer_done && ped_pending) begin
            ped_pending <= 1'b0;
        end else if (ped_req && (state_q != PED)) begin
            ped_pending <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MG:      if (tif.timer_done && mg_request) state_d = MY;
            MY:      if (tif.timer_done) state_d = AR1;
            AR1:     if (tif.timer_done) state_d = SG;
            SG:      if (tif.timer_done) state_d = SY;
            SY:      if (tif.timer_done) state_d = AR2;
            AR2:     if (tif.timer_done) state_d = ped_pending ? PED : MG;
            PED:     if (tif.timer_done) state_d = MG;
            default: state_d = MG;
        endcase
    end

    // In an idle main green the timer is frozen at its limit so done stays high until a request.
    always_comb begin
        main_light   = RED;
        side_light   = RED;
        ped_walk     = 1'b0;
        tif.t_max    = LIM_MG;
        tif.timer_en = 1'b1;
        case (state_q)
            MG: begin
                main_light   = GREEN;
                tif.t_max    = LIM_MG;
                tif.timer_en = ~(tif.timer_done & ~mg_request);
            end
            MY: begin
                main_light = YELLOW;
                tif.t_max  = LIM_Y;
            end
            AR1: begin
                tif.t_max = LIM_AR;
            end
            SG: begin
                side_light = GREEN;
                tif.t_max  = LIM_SG;
            end
            SY: begin
                side_light = YELLOW;
                tif.t_max  = LIM_Y;
            end
            AR2: begin
                tif.t_max = LIM_AR;
            end
            PED: begin
                ped_walk  = 1'b1;
                tif.t_max = LIM_PED;
            end
            default: begin
                main_light = GREEN;
            end
        endcase
    end

endmodule

// File: tb/tb_tlc_phase_fsm.sv
// Bench for tlc_phase_fsm: drives it beside a behavioural timer and compares every cycle
// against a phase/elapsed-time model of the intersection.
module tb_tlc_phase_fsm;

    logic       clk;
    logic       res_n;
    logic       sideCar;
    logic       pedReq;
    logic [2:0] mainLight;
    logic [2:0] sideLight;
    logic       pedWalk;
    logic [2:0] state;
    logic [5:0] timerCount;

    int checkCount;
    int passCount;

    int modelPhase;
    int modelElapsed;
    int modelPending;

    int limTab[7]  = '{9, 2, 1, 7, 2, 1, 5};
    int mainTab[7] = '{1, 2, 4, 4, 4, 4, 4};
    int sideTab[7] = '{4, 4, 4, 1, 2, 4, 4};

    tlc_phase_fsm_if #(.n(6)) tif ();

    tlc_phase_fsm dut (
        .clk        (clk),
        .res_n      (res_n),
        .side_car   (sideCar),
        .ped_req    (pedReq),
        .tif        (tif),
        .main_light (mainLight),
        .side_light (sideLight),
        .ped_walk   (pedWalk),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared timer the sequencer controls.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            timerCount <= '0;
        end else if (tif.timer_en) begin
            timerCount <= (timerCount >= tif.t_max) ? 6'd0 : timerCount + 6'd1;
        end
    end
    assign tif.timer_done = (timerCount == tif.t_max);

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        modelPhase   = 0;
        modelElapsed = 0;
        modelPending = 0;
    endtask

    task automatic applyStimulus(input bit sc, input bit pr);
        bit done;
        int nextPending;
        int expEn;
        @(negedge clk);
        sideCar = sc;
        pedReq  = pr;
        #1;
        expEn = (modelPhase == 0 && modelElapsed == limTab[0] && !sc && modelPending == 0) ? 0 : 1;
        checkOutput("state",      int'(state),      modelPhase);
        checkOutput("mainLight",  int'(mainLight),  mainTab[modelPhase]);
        checkOutput("sideLight",  int'(sideLight),  sideTab[modelPhase]);
        checkOutput("pedWalk",    int'(pedWalk),    (modelPhase == 6) ? 1 : 0);
        checkOutput("tMax",       int'(tif.t_max),  limTab[modelPhase]);
        checkOutput("timerEn",    int'(tif.timer_en), expEn);
        checkOutput("timerCount", int'(timerCount), modelElapsed);

        done        = (modelElapsed == limTab[modelPhase]);
        nextPending = modelPending;
        if (modelPhase != 6 && pr) nextPending = 1;
        if (modelPhase == 5 && done && modelPending != 0) nextPending = 0;
        if (!done) begin
            modelElapsed++;
        end else if (modelPhase == 0) begin
            if (sc || modelPending != 0) begin
                modelPhase   = 1;
                modelElapsed = 0;
            end
        end else begin
            if (modelPhase == 5) modelPhase = (modelPending != 0) ? 6 : 0;
            else if (modelPhase == 6) modelPhase = 0;
            else modelPhase = modelPhase + 1;
            modelElapsed = 0;
        end
        modelPending = nextPending;
    endtask

    // Reset is asserted between edges, so the outputs must change before any clock.
    task automatic doReset();
        @(negedge clk);
        res_n   = 1'b0;
        sideCar = 1'b0;
        pedReq  = 1'b0;
        #1;
        checkOutput("rstState",  int'(state),        0);
        checkOutput("rstMain",   int'(mainLight),    1);
        checkOutput("rstSide",   int'(sideLight),    4);
        checkOutput("rstWalk",   int'(pedWalk),      0);
        checkOutput("rstTMax",   int'(tif.t_max),    9);
        checkOutput("rstTimerEn", int'(tif.timer_en), 1);
        @(posedge clk);
        #1 res_n = 1'b1;
        resetModel();
    endtask

    task automatic runUntil(input int ph, input bit sc);
        int guard = 0;
        while (modelPhase != ph && guard < 200) begin
            applyStimulus(sc, 1'b0);
            guard++;
        end
        if (modelPhase != ph) checkOutput("reachPhase", modelPhase, ph);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        res_n      = 1'b0;
        sideCar    = 1'b0;
        pedReq     = 1'b0;
        resetModel();

        doReset();
        repeat (30) applyStimulus(1'b1, 1'b0);

        doReset();
        repeat (20) applyStimulus(1'b0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b0);

        runUntil(3, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (30) applyStimulus(1'b1, 1'b0);

        doReset();
        repeat (15) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (45) applyStimulus(1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1);
        repeat (40) applyStimulus(1'b0, (modelPhase >= 5) ? 1'b1 : 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b0);

        repeat (1500) applyStimulus(($urandom % 4) == 0, ($urandom % 16) == 0);

        runUntil(3, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0);
        doReset();
        repeat (12) applyStimulus(1'b1, 1'b0);

        runUntil(4, 1'b1);
        @(negedge clk);
        force dut.state_q = 3'd7;
        #1 release dut.state_q;
        @(negedge clk);
        #1;
        checkOutput("illegalState", int'(state),     0);
        checkOutput("illegalMain",  int'(mainLight), 1);

        doReset();
        repeat (5) applyStimulus(1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
